fp_mult_arbiter: RTL and testbench

Shares one pipelined fp_mult instance among NUM_REQ requesters. The block arbitrates round-robin, issues at most one operand pair per cycle, and carries each requester ID alongside the multiplier pipeline. It returns every result with its ID over a single valid/ready response port, and freezes the multiplier through its enable when the consumer applies backpressure. It sits between the FP-unit request crossbar and the fp_mult datapath.

---
 rtl/fp_mult_arbiter.sv | 148 ++++++++++++++
 tb/tb_fp_mult_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter
//   Shares one pipelined fp_mult among NUM_REQ requesters. Operand pairs are
//   granted round-robin, at most one per cycle. Each requester ID travels in
//   a tag pipeline that runs alongside the multiplier's PIPE_STAGES registers,
//   so every result comes back with its ID on one valid/ready response port.
//   Backpressure freezes the multiplier and the tag pipeline together through
//   mult_enable.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b        packed operands, requester i at [i*W +: W]
//   req_round          packed rounding modes, requester i at [i*3 +: 3]
//   resp_valid/ready   result handshake
//   resp_id            requester index of the presented result
//   resp_z/status      product and flags, passed through from fp_mult
//   mult_a/b/round     operands to fp_mult (don't-care when nothing issues)
//   mult_enable        fp_mult enable, low only while the response is stalled
//   mult_z/status      fp_mult outputs
//   inflight           number of valid ops held in the pipeline
module fp_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SIG_WIDTH   = 23,
    parameter int EX_WIDTH    = 8,
    parameter int PIPE_STAGES = 3,
    localparam int W   = SIG_WIDTH + EX_WIDTH + 1,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW  = $clog2(PIPE_STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*W-1:0]   req_a,
    input  logic [NUM_REQ*W-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]   req_round,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [W-1:0]           resp_z,
    output logic [7:0]             resp_status,
    output logic [W-1:0]           mult_a,
    output logic [W-1:0]           mult_b,
    output logic [2:0]             mult_round,
    output logic                   mult_enable,
    input  logic [W-1:0]           mult_z,
    input  logic [7:0]             mult_status,
    output logic [CW-1:0]          inflight
);

    localparam int unsigned NRU = NUM_REQ;
    localparam int unsigned PSU = PIPE_STAGES;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_id;
    logic           grant_any;
    logic [IDW-1:0] sel_id;
    logic           transfer;
    logic           accept;

    logic [PIPE_STAGES-1:0] tag_v;
    logic [IDW-1:0]         tag_id [PIPE_STAGES];

    // (base + off) mod NUM_REQ; NUM_REQ need not be a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned   off);
        int unsigned s;
        s = 32'(base) + off;
        return IDW'(s % NRU);
    endfunction

    // The response register is the last tag stage; it only holds while a
    // presented result is not taken.
    assign resp_valid  = tag_v[PIPE_STAGES-1];
    assign resp_id     = tag_id[PIPE_STAGES-1];
    assign resp_z      = mult_z;
    assign resp_status = mult_status;
    assign mult_enable = ~(resp_valid & ~resp_ready);
    assign accept      = resp_valid & resp_ready;

    // Round-robin search: first valid requester starting at ptr.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NRU; i++) begin
            idx = wrap_add(ptr, i);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    assign transfer = grant_any & mult_enable;

    always_comb begin
        req_ready = '0;
        if (transfer) req_ready[grant_id] = 1'b1;
    end

    // Operand mux follows the grant, or ptr when idle.
    assign sel_id = grant_any ? grant_id : ptr;

    always_comb begin
        mult_a     = req_a[int'(sel_id)*W +: W];
        mult_b     = req_b[int'(sel_id)*W +: W];
        mult_round = req_round[int'(sel_id)*3 +: 3];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= wrap_add(grant_id, 1);
        end
    end

    // Tag pipeline mirrors fp_mult's registers: shifts only when enabled,
    // so bubbles are kept and frozen exactly like real ops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_v <= '0;
            for (int unsigned k = 0; k < PSU; k++) tag_id[k] <= '0;
        end else if (mult_enable) begin
            tag_v[0]  <= transfer;
            tag_id[0] <= grant_id;
            for (int unsigned k = 1; k < PSU; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Kept as a counter rather than a popcount of tag_v: an op leaves the
    // pipe only by being accepted, so +transfer -accept tracks the same value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight <= '0;
        end else if (transfer && !accept) begin
            inflight <= inflight + 1'b1;
        end else if (!transfer && accept) begin
            inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Testbench for fp_mult_arbiter (NUM_REQ=4, PIPE_STAGES=3, 32-bit words).
// A small behavioural stand-in for fp_mult (enable-gated pipeline with a
// fixed result function) is attached to the mult_* ports.
module tb_fp_mult_arbiter;

    localparam int NR = 4;
    localparam int P  = 3;
    localparam int W  = 32;

    logic             clk;
    logic             resetn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*W-1:0]  req_a;
    logic [NR*W-1:0]  req_b;
    logic [NR*3-1:0]  req_round;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [W-1:0]     resp_z;
    logic [7:0]       resp_status;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic [2:0]       mult_round;
    logic             mult_enable;
    logic [W-1:0]     mult_z;
    logic [7:0]       mult_status;
    logic [1:0]       inflight;

    fp_mult_arbiter #(.NUM_REQ(NR), .SIG_WIDTH(23), .EX_WIDTH(8), .PIPE_STAGES(P)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_round(req_round),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_z(resp_z), .resp_status(resp_status),
        .mult_a(mult_a), .mult_b(mult_b), .mult_round(mult_round),
        .mult_enable(mult_enable), .mult_z(mult_z), .mult_status(mult_status),
        .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in multiplier result: {status, z}.
    function automatic logic [39:0] fmul_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] r);
        logic a_inf, b_inf, a_zero, b_zero;
        a_inf  = (a[30:0] == 31'h7F800000);
        b_inf  = (b[30:0] == 31'h7F800000);
        a_zero = (a[30:0] == 31'h0);
        b_zero = (b[30:0] == 31'h0);
        if (a == 32'h3FC00000 && b == 32'h40000000) return {8'h00, 32'h40400000};
        if ((a_inf && b_zero) || (a_zero && b_inf)) return {8'h04, 32'h7FC00000};
        return {({5'b0, r} ^ a[7:0]), ((a * 32'd3) ^ (b + {29'b0, r}))};
    endfunction

    logic [39:0] sp [P];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < P; k++) sp[k] <= '0;
        end else if (mult_enable) begin
            sp[0] <= fmul_model(mult_a, mult_b, mult_round);
            for (int k = 1; k < P; k++) sp[k] <= sp[k-1];
        end
    end
    assign mult_z      = sp[P-1][31:0];
    assign mult_status = sp[P-1][39:32];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [31:0] op_a [NR];
    logic [31:0] op_b [NR];
    logic [2:0]  op_r [NR];

    task automatic pack_ops();
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W]     = op_a[i];
            req_b[i*W +: W]     = op_b[i];
            req_round[i*3 +: 3] = op_r[i];
        end
    endtask

    // Called at a negedge; leaves time 3 units before the next posedge.
    task automatic do_reset();
        req_valid  = '0;
        resp_ready = 1'b1;
        resetn     = 1'b0;
        #2;
        resetn     = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] v;
        bit         rdy;
        logic [3:0] e_rr;
        bit         e_rv;
        int         e_id;
        int         e_infl;
        bit         e_en;
    } row_t;
    row_t tbl[$];

    task automatic add(input bit rst, input logic [3:0] v, input bit rdy, input logic [3:0] e_rr,
                       input bit e_rv, input int e_id, input int e_infl, input bit e_en);
        row_t r;
        r.rst = rst; r.v = v; r.rdy = rdy; r.e_rr = e_rr;
        r.e_rv = e_rv; r.e_id = e_id; r.e_infl = e_infl; r.e_en = e_en;
        tbl.push_back(r);
    endtask

    typedef struct {
        int          id;
        logic [39:0] res;
        longint      due;
    } tok_t;
    tok_t        q[$];
    tok_t        t;
    int          mptr;
    longint      ecount;
    int          g;
    int          idx;
    bit          e_rv;
    bit          e_en;
    logic [3:0]  e_rr;
    logic [39:0] e_res;

    initial begin
        resetn     = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        // Fixed table operands: req0 inf*0, req2 1.5*2.0.
        op_a[0] = 32'h7F800000; op_b[0] = 32'h00000000; op_r[0] = 3'd0;
        op_a[1] = 32'h12345678; op_b[1] = 32'h0BADF00D; op_r[1] = 3'd1;
        op_a[2] = 32'h3FC00000; op_b[2] = 32'h40000000; op_r[2] = 3'd0;
        op_a[3] = 32'hCAFEBABE; op_b[3] = 32'h00C0FFEE; op_r[3] = 3'd3;
        pack_ops();
        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, 2'd0);
        chk("rst_inflight", inflight, 2'd0);
        chk("rst_mult_enable", mult_enable, 1'b1);
        next_cycle();

        // Single op from req 2
        add(0, 4'b0100, 1, 4'b0100, 0, 0, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 1, 2, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
        // All valid, backpressure in cycles 4-7
        add(1, 4'b1111, 1, 4'b0001, 0, 0, 0, 1);
        add(0, 4'b1111, 1, 4'b0010, 0, 0, 1, 1);
        add(0, 4'b1111, 1, 4'b0100, 0, 0, 2, 1);
        add(0, 4'b1111, 1, 4'b1000, 1, 0, 3, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b1111, 0, 4'b0000, 1, 1, 3, 0);
        add(0, 4'b1111, 1, 4'b0001, 1, 1, 3, 1);
        add(0, 4'b1111, 1, 4'b0010, 1, 2, 3, 1);
        add(0, 4'b1111, 1, 4'b0100, 1, 3, 3, 1);
        add(0, 4'b1111, 1, 4'b1000, 1, 0, 3, 1);
        // Sparse traffic from req 1; next grant with all valid is 2
        add(1, 4'b0010, 1, 4'b0010, 0, 0, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0010, 1, 4'b0010, 0, 0, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 2, 1);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0000, 1, 4'b0000, 1, 1, 1, 1);
        add(0, 4'b1111, 1, 4'b0100, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req_valid  = tbl[i].v;
            resp_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_rr);
            chk($sformatf("tbl%0d_resp_valid", i), resp_valid, tbl[i].e_rv);
            chk($sformatf("tbl%0d_mult_enable", i), mult_enable, tbl[i].e_en);
            chk($sformatf("tbl%0d_inflight", i), inflight, 64'(tbl[i].e_infl));
            if (tbl[i].e_rv) begin
                e_res = fmul_model(op_a[tbl[i].e_id], op_b[tbl[i].e_id], op_r[tbl[i].e_id]);
                chk($sformatf("tbl%0d_resp_id", i), resp_id, 64'(tbl[i].e_id));
                chk($sformatf("tbl%0d_resp_z", i), resp_z, e_res[31:0]);
                chk($sformatf("tbl%0d_resp_status", i), resp_status, e_res[39:32]);
            end
            next_cycle();
        end

        // Special values: inf * 0 from req 0
        do_reset();
        req_valid = 4'b0001;
        #1;
        chk("nan_req_ready", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        #1;
        chk("nan_resp_valid", resp_valid, 1'b1);
        chk("nan_resp_id", resp_id, 2'd0);
        chk("nan_exp_all_ones", resp_z[30:23], 8'hFF);
        chk("nan_mant_nonzero", (resp_z[22:0] != 23'd0), 1'b1);
        chk("nan_status2", resp_status[2], 1'b1);
        next_cycle();

        // Reset in the middle of two in-flight ops
        do_reset();
        req_valid = 4'b0011;
        #1;
        chk("mr_grant0", req_ready, 4'b0001);
        next_cycle();
        #1;
        chk("mr_grant1", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b1111;
        #1;
        chk("mr_inflight_before", inflight, 2'd2);
        resetn = 1'b0;
        #1;
        chk("mr_resp_valid_async", resp_valid, 1'b0);
        chk("mr_inflight_async", inflight, 2'd0);
        chk("mr_ptr_zero", req_ready, 4'b0001);
        resetn = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("mr_fresh_grant", req_ready, 4'b1000);
        next_cycle();
        req_valid = '0;
        for (int i = 1; i <= 2; i++) begin
            #1;
            chk($sformatf("mr_no_stale_c%0d", i), resp_valid, 1'b0);
            next_cycle();
        end
        #1;
        e_res = fmul_model(op_a[3], op_b[3], op_r[3]);
        chk("mr_fresh_valid", resp_valid, 1'b1);
        chk("mr_fresh_id", resp_id, 2'd3);
        chk("mr_fresh_z", resp_z, e_res[31:0]);
        next_cycle();
        #1;
        chk("mr_after_valid", resp_valid, 1'b0);
        next_cycle();

        // Randomised traffic against a transaction-level model: each accepted
        // op is due PIPE enabled cycles after acceptance, results in order.
        do_reset();
        mptr   = 0;
        ecount = 0;
        q.delete();
        repeat (500) begin
            for (int i = 0; i < NR; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
                op_r[i] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) begin
                op_a[0] = 32'h7F800000;
                op_b[0] = 32'h00000000;
            end
            pack_ops();
            req_valid  = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_rv = (q.size() > 0) && (q[0].due == ecount);
            e_en = !(e_rv && !resp_ready);
            g = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (mptr + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            e_rr = (e_en && g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rnd_req_ready", req_ready, e_rr);
            chk("rnd_resp_valid", resp_valid, e_rv);
            chk("rnd_mult_enable", mult_enable, e_en);
            chk("rnd_inflight", inflight, 64'(q.size()));
            if (e_rv) begin
                chk("rnd_resp_id", resp_id, 64'(q[0].id));
                chk("rnd_resp_z", resp_z, q[0].res[31:0]);
                chk("rnd_resp_status", resp_status, q[0].res[39:32]);
            end
            @(posedge clk);
            if (e_en) begin
                if (e_rv) void'(q.pop_front());
                if (g >= 0) begin
                    t.id  = g;
                    t.res = fmul_model(op_a[g], op_b[g], op_r[g]);
                    t.due = ecount + P;
                    q.push_back(t);
                    mptr = (g + 1) % NR;
                end
                ecount++;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
